// File: rtl/add_fu.sv
// add_fu: integer add/subtract functional unit sitting in front of the
// 16-bit adder. It takes an issued instruction, waits for operands, runs a
// fixed execute latency, then holds the result until writeback is granted.
module add_fu #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic             issue_op,
  input  logic [TAG_W-1:0] issue_dest,
  output logic             issue_ready,
  input  logic             rd_valid,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             fu_busy,
  output logic             fu_op,
  output logic [TAG_W-1:0] fu_dest,
  output logic             wb_req,
  input  logic             wb_grant,
  output logic [WIDTH-1:0] wb_data,
  output logic             wb_cout,
  output logic             wb_ovf
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    EXEC     = 2'd2,
    WB       = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t           state;
  state_t           next_state;
  logic [3:0]       cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH:0]   sum_full;
  logic             sum_ovf;

  // Adder fed from the captured operands; op_b is already inverted for subtract.
  assign sum_full = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin};
  assign sum_ovf  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                    (sum_full[WIDTH-1] != op_a[WIDTH-1]);

  // Next-state logic; flush overrides every other input.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (issue_valid) next_state = WAIT_OPS;
      WAIT_OPS: if (rd_valid)    next_state = EXEC;
      EXEC:     if (cnt == 4'd0) next_state = WB;
      WB:       if (wb_grant)    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
    if (flush) next_state = IDLE;
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      issue_ready <= 1'b1;
      fu_busy     <= 1'b0;
      wb_req      <= 1'b0;
    end else begin
      state       <= next_state;
      issue_ready <= (next_state == IDLE);
      fu_busy     <= (next_state != IDLE);
      wb_req      <= (next_state == WB);
    end
  end

  // Instruction fields, operand capture, latency counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_op   <= 1'b0;
      fu_dest <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      cnt     <= 4'd0;
      wb_data <= '0;
      wb_cout <= 1'b0;
      wb_ovf  <= 1'b0;
    end else if (flush) begin
      fu_op   <= 1'b0;
      fu_dest <= '0;
      op_a    <= '0;
      op_b    <= '0;
      op_cin  <= 1'b0;
      cnt     <= 4'd0;
      wb_data <= '0;
      wb_cout <= 1'b0;
      wb_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (issue_valid) begin
            fu_op   <= issue_op;
            fu_dest <= issue_dest;
          end
        end
        WAIT_OPS: begin
          if (rd_valid) begin
            op_a   <= src_a;
            op_b   <= fu_op ? ~src_b : src_b;
            op_cin <= fu_op;
            cnt    <= CNT_LOAD;
          end
        end
        EXEC: begin
          if (cnt == 4'd0) begin
            wb_data <= sum_full[WIDTH-1:0];
            wb_cout <= sum_full[WIDTH];
            wb_ovf  <= sum_ovf;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WB: begin
          if (wb_grant) begin
            fu_op   <= 1'b0;
            fu_dest <= '0;
            wb_data <= '0;
            wb_cout <= 1'b0;
            wb_ovf  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
